// File: rtl/switch_event_pkg.sv
// Shared definitions for the switch event controller: event code fields,
// per-switch FSM state encodings and a helper that packs an event code.
// Optional feature macro used by this codebase: SWITCH_EVENT_LONG_EN
// (defined: SHORT/LONG detection; undefined: every press is SHORT).
package switch_event_pkg;

  // Event type (bit0 of the event code)
  localparam logic EV_SHORT = 1'b0;
  localparam logic EV_LONG  = 1'b1;

  // Switch id (bit1 of the event code)
  localparam logic SW_ID1 = 1'b0;
  localparam logic SW_ID2 = 1'b1;

  // Per-switch FSM state encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  typedef logic [1:0] ev_code_t;

  // Event code layout: {switch id, event type}
  function automatic ev_code_t make_code(input logic sw_id, input logic ev_type);
    return {sw_id, ev_type};
  endfunction

endpackage

// File: rtl/switch_event_fsm.sv
// One switch's press classifier: IDLE/PRESSED/HELD FSM, hold counter and a
// single-entry pending register that the top-level arbiter drains.
// With SWITCH_EVENT_LONG_EN undefined there is no hold counter, HELD is never
// entered and every press yields SHORT on release.
module switch_event_fsm
  import switch_event_pkg::*;
#(
  parameter int unsigned LONG_LIMIT = 25000000,
  parameter logic        SW_ID      = SW_ID1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Level,
  input  logic       i_Grant,
  output logic       o_Req,
  output ev_code_t   o_Code,
  output logic       o_Drop,
  output logic [1:0] o_State
);

  if (LONG_LIMIT < 2) begin : g_limit_check
    $error("switch_event_fsm: LONG_LIMIT must be at least 2");
  end

  logic [1:0] state_q, state_d;
  logic       pend_vld_q, pend_vld_d;
  logic       pend_type_q, pend_type_d;
  logic       new_ev;
  logic       new_type;
  logic       pend_free;

`ifdef SWITCH_EVENT_LONG_EN
  localparam int unsigned     CNT_W    = $clog2(LONG_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_LIMIT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-state logic: classify the press and flag a new event
  always_comb begin
    state_d  = state_q;
    new_ev   = 1'b0;
    new_type = EV_SHORT;
`ifdef SWITCH_EVENT_LONG_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_Level) begin
          state_d = ST_PRESSED;
`ifdef SWITCH_EVENT_LONG_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_PRESSED: begin
        if (!i_Level) begin
          new_ev   = 1'b1;
          new_type = EV_SHORT;
          state_d  = ST_IDLE;
        end
`ifdef SWITCH_EVENT_LONG_EN
        // Counter stops at the limit, so it never wraps
        else if (cnt_q == CNT_LAST) begin
          new_ev   = 1'b1;
          new_type = EV_LONG;
          state_d  = ST_HELD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_HELD: begin
        // The LONG event was already issued; release is silent
        if (!i_Level) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending register: a grant this edge frees the slot for a new event
  always_comb begin
    pend_free   = !pend_vld_q || i_Grant;
    o_Drop      = new_ev && !pend_free;
    pend_vld_d  = pend_vld_q && !i_Grant;
    pend_type_d = pend_type_q;
    if (new_ev && pend_free) begin
      pend_vld_d  = 1'b1;
      pend_type_d = new_type;
    end
  end

  // State, counter and pending registers
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= ST_IDLE;
      pend_vld_q  <= 1'b0;
      pend_type_q <= EV_SHORT;
`ifdef SWITCH_EVENT_LONG_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_type_q <= pend_type_d;
`ifdef SWITCH_EVENT_LONG_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign o_Req   = pend_vld_q;
  assign o_Code  = make_code(SW_ID, pend_type_q);
  assign o_State = state_q;

endmodule

// File: rtl/switch_event_ctrl.sv
// Switch event controller top: two press classifiers, a round-robin arbiter
// and an event FIFO drained by the application.
// Optional feature macro: SWITCH_EVENT_LONG_EN (long-press detection).
//
// Handshake: o_Event_Valid is high whenever the FIFO holds an event and
// o_Event_Code shows the oldest one; the head is consumed on every rising
// edge where o_Event_Valid && i_Event_Ready. Valid does not depend on ready.
module switch_event_ctrl
  import switch_event_pkg::*;
#(
  parameter int unsigned LONG_LIMIT = 25000000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            i_Clk,
  input  logic                            i_Rst,
  input  logic                            i_Switch1,
  input  logic                            i_Switch2,
  output logic                            o_Event_Valid,
  input  logic                            i_Event_Ready,
  output logic [1:0]                      o_Event_Code,
  output logic                            o_Overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_Fifo_Count,
  output logic [3:0]                      o_Dbg_State
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("switch_event_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end

  logic       req1, req2;
  logic       grant1, grant2;
  logic       drop1, drop2;
  ev_code_t   code1, code2;
  logic [1:0] state1, state2;

  logic             last_q, last_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  ev_code_t         mem_q [FIFO_DEPTH];

  logic     full;
  logic     pop;
  logic     push;
  logic     push_ok;
  ev_code_t push_code;

  switch_event_fsm #(
    .LONG_LIMIT (LONG_LIMIT),
    .SW_ID      (SW_ID1)
  ) u_fsm_sw1 (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Level (i_Switch1),
    .i_Grant (grant1),
    .o_Req   (req1),
    .o_Code  (code1),
    .o_Drop  (drop1),
    .o_State (state1)
  );

  switch_event_fsm #(
    .LONG_LIMIT (LONG_LIMIT),
    .SW_ID      (SW_ID2)
  ) u_fsm_sw2 (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Level (i_Switch2),
    .i_Grant (grant2),
    .o_Req   (req2),
    .o_Code  (code2),
    .o_Drop  (drop2),
    .o_State (state2)
  );

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = o_Event_Valid && i_Event_Ready;
  assign push_ok = !full || pop;

  // Round-robin arbiter: contention goes to the switch opposite the last grant
  always_comb begin
    grant1 = 1'b0;
    grant2 = 1'b0;
    if (push_ok) begin
      if (req1 && req2) begin
        if (last_q == SW_ID2) grant1 = 1'b1;
        else                  grant2 = 1'b1;
      end else if (req1) begin
        grant1 = 1'b1;
      end else if (req2) begin
        grant2 = 1'b1;
      end
    end
    push      = grant1 || grant2;
    push_code = grant1 ? code1 : code2;
    last_d    = last_q;
    if (grant1) last_d = SW_ID1;
    if (grant2) last_d = SW_ID2;
  end

  // Occupancy and sticky overflow next-state
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    ovf_d = ovf_q || drop1 || drop2;
  end

  // Control registers: pointers, count, arbiter pointer, overflow flag
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= SW_ID2;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  // Event storage; cleared on reset so the idle head reads as code 0
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_code;
    end
  end

  assign o_Event_Valid = (count_q != '0);
  assign o_Event_Code  = mem_q[rd_ptr_q];
  assign o_Overflow    = ovf_q;
  assign o_Fifo_Count  = count_q;
  assign o_Dbg_State   = {state2, state1};

endmodule

// File: tb/tb_switch_event_ctrl.sv
// Bench for switch_event_ctrl: directed scenarios plus a random phase, with a
// press-duration reference model feeding an expected-event queue.
module tb_switch_event_ctrl;

  localparam int LIMIT = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef SWITCH_EVENT_LONG_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic          i_Clk = 1'b0;
  logic          i_Rst = 1'b1;
  logic          i_Switch1 = 1'b0;
  logic          i_Switch2 = 1'b0;
  logic          i_Event_Ready = 1'b0;
  logic          o_Event_Valid;
  logic [1:0]    o_Event_Code;
  logic          o_Overflow;
  logic [CW-1:0] o_Fifo_Count;
  logic [3:0]    o_Dbg_State;

  switch_event_ctrl #(
    .LONG_LIMIT (LIMIT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Rst         (i_Rst),
    .i_Switch1     (i_Switch1),
    .i_Switch2     (i_Switch2),
    .o_Event_Valid (o_Event_Valid),
    .i_Event_Ready (i_Event_Ready),
    .o_Event_Code  (o_Event_Code),
    .o_Overflow    (o_Overflow),
    .o_Fifo_Count  (o_Fifo_Count),
    .o_Dbg_State   (o_Dbg_State)
  );

  // ---------------- clock ----------------
  always #5 i_Clk = ~i_Clk;

  // ---------------- scoreboard state ----------------
  int         errors = 0;
  int         checks = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_e;

  // Reference model: press durations in sampled clocks per switch
  bit model_en = 1'b1;
  int hold_len [2];
  bit long_done[2];
  bit last_sw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    hold_len[0]  = 0;
    hold_len[1]  = 0;
    long_done[0] = 1'b0;
    long_done[1] = 1'b0;
    last_sw      = 1'b1;
    exp_q.delete();
  endtask

  // Apply one sampled edge to the model: a press held for more than LIMIT
  // sampled clocks is LONG (when enabled), otherwise release yields SHORT.
  // Events born on the same edge reach the FIFO opposite-of-last first.
  task automatic model_edge(input logic a, input logic b);
    bit   ev [2];
    logic typ[2];
    logic lv [2];
    bit   first;
    lv[0] = a;
    lv[1] = b;
    for (int sw = 0; sw < 2; sw++) begin
      ev[sw]  = 1'b0;
      typ[sw] = 1'b0;
      if (lv[sw]) begin
        hold_len[sw]++;
        if (LONG_EN && !long_done[sw] && hold_len[sw] == LIMIT + 1) begin
          ev[sw]        = 1'b1;
          typ[sw]       = 1'b1;
          long_done[sw] = 1'b1;
        end
      end else begin
        if (hold_len[sw] > 0 && !long_done[sw]) begin
          ev[sw]  = 1'b1;
          typ[sw] = 1'b0;
        end
        hold_len[sw]  = 0;
        long_done[sw] = 1'b0;
      end
    end
    if (ev[0] && ev[1]) begin
      first = ~last_sw;
      exp_q.push_back({first, typ[first]});
      exp_q.push_back({~first, typ[~first]});
      last_sw = ~first;
    end else if (ev[0]) begin
      exp_q.push_back({1'b0, typ[0]});
      last_sw = 1'b0;
    end else if (ev[1]) begin
      exp_q.push_back({1'b1, typ[1]});
      last_sw = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic a, input logic b, input logic r);
    i_Switch1     = a;
    i_Switch2     = b;
    i_Event_Ready = r;
    if (i_Rst)         model_reset();
    else if (model_en) model_edge(a, b);
    @(posedge i_Clk);
    #1;
  endtask

  task automatic press_sw1(input logic r);
    step(1'b1, 1'b0, r);
    step(1'b1, 1'b0, r);
    step(1'b0, 1'b0, r);
    step(1'b0, 1'b0, r);
  endtask

  task automatic do_reset(input logic a);
    i_Rst = 1'b1;
    step(a, 1'b0, 1'b0);
    step(a, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, o_Event_Valid, 0);
    check({tag, "_code"},  o_Event_Code,  0);
    check({tag, "_ovf"},   o_Overflow,    0);
    check({tag, "_count"}, o_Fifo_Count,  0);
  endtask

  // Keep the consumer ready until every expected event is seen (bounded)
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge i_Clk) begin
    if (!i_Rst && o_Event_Valid && i_Event_Ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %0b, expected none (t=%0t)", o_Event_Code, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_code", o_Event_Code, mon_e);
      end
    end
  end

  // ---------------- stimulus ----------------
  bit lvl[2];
  int rem[2];

  initial begin
    model_reset();
    do_reset(1'b0);
    check_reset_outputs("reset");
    check("reset_dbg_state", o_Dbg_State, 0);
    i_Rst = 1'b0;

    // T1: short press of Switch1, valid two edges after release
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("t1_valid_after_release", o_Event_Valid, 0);
    step(1'b0, 1'b0, 1'b1);
    check("t1_valid_next", o_Event_Valid, 1);
    check("t1_count", o_Fifo_Count, 1);
    drain("t1_drained");

    // T2: hold Switch2 for 40 clocks
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (i == 17) check("t2_valid_before_long", o_Event_Valid, 0);
      if (i == 18) check("t2_valid_long", o_Event_Valid, LONG_EN);
    end
    step(1'b0, 1'b0, 1'b1);
    drain("t2_drained");

    // T3: simultaneous releases, then a solo Switch1 event flips the order
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("t3_valid_first", o_Event_Valid, 1);
    step(1'b0, 1'b0, 1'b1);
    check("t3_valid_second", o_Event_Valid, 1);
    drain("t3_drained_a");
    press_sw1(1'b1);
    drain("t3_drained_solo");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    drain("t3_drained_b");

    // T6: full FIFO, pop and pending push on the same edge as a new event
    model_en = 1'b0;
    do_reset(1'b0);
    i_Rst = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(2'b00);
    for (int i = 0; i < 5; i++) press_sw1(1'b0);
    check("t6_count_full", o_Fifo_Count, 4);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("t6_count_same_edge", o_Fifo_Count, 4);
    check("t6_no_drop", o_Overflow, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t6_count_hold", o_Fifo_Count, 4);
    drain("t6_drained");
    check("t6_count_empty", o_Fifo_Count, 0);
    check("t6_ovf_final", o_Overflow, 0);

    // T4: seven presses with the consumer stalled
    do_reset(1'b0);
    i_Rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      press_sw1(1'b0);
      check($sformatf("t4_count_%0d", i), o_Fifo_Count, (i < 4) ? i : 4);
      check($sformatf("t4_ovf_%0d", i), o_Overflow, (i >= 6) ? 1 : 0);
    end
    for (int i = 0; i < 5; i++) exp_q.push_back(2'b00);
    drain("t4_drained");
    check("t4_ovf_sticky", o_Overflow, 1);
    check("t4_count_empty", o_Fifo_Count, 0);
    model_en = 1'b1;

    // T5: Switch1 high across reset release, then reset mid-press
    do_reset(1'b1);
    check_reset_outputs("t5_reset");
    i_Rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    drain("t5_across_reset");
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t5_queued", o_Fifo_Count, 1);
    check("t5_queued_code", o_Event_Code, 2'b10);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    do_reset(1'b0);
    check_reset_outputs("t5_midpress");
    i_Rst = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
    check("t5_no_event", exp_q.size(), 0);

    // Random phase against the model
    do_reset(1'b0);
    i_Rst = 1'b0;
    lvl[0] = 1'b0;
    lvl[1] = 1'b0;
    rem[0] = 0;
    rem[1] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int sw = 0; sw < 2; sw++) begin
        if (rem[sw] == 0) begin
          lvl[sw] = ~lvl[sw];
          if (lvl[sw])
            rem[sw] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 24))
                                                  : int'($urandom_range(1, 6));
          else
            rem[sw] = int'($urandom_range(1, 5));
        end
        rem[sw]--;
      end
      step(lvl[0], lvl[1], 1'b1);
    end
    step(1'b0, 1'b0, 1'b1);
    drain("random_drained");
    check("random_no_ovf", o_Overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
